core_fft_load_ctrl: RTL

CORE_FFT_LOAD_CTRL -- requirements
Module: core_fft_load_ctrl

---
 rtl/core_fft_load_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/core_fft_load_ctrl.sv
// Ping-pong sample loader for an in-place FFT engine: writes incoming samples into
// even/odd sub-buffers, then hands each full buffer to the engine. Option: CORE_FFT_LOAD_DROP_EN.
module core_fft_load_ctrl #(
  parameter int LOGPTS = 8,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              fft_done,
  output logic [DWIDTH-1:0] ldData,
  output logic [LOGPTS-2:0] wA_load,
  output logic              wEn_even,
  output logic              wEn_odd,
  output logic              ping,
  output logic              pong,
  output logic              load,
  output logic              fft_start,
  output logic              ovfl
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state_q;
  logic [LOGPTS-1:0]   cnt_q;
  logic                fill_bank_q;
  logic                hand_q;
  logic                hand_bank_q;
  logic [DWIDTH-1:0]   ldata_q;
  logic [LOGPTS-2:0]   wa_q;
  logic                wen_even_q;
  logic                wen_odd_q;
  logic                ping_q;
  logic                pong_q;
  logic                start_q;
  logic                ovfl_q;

  logic ready_d;
  logic accept_d;
  logic drop_d;
  logic owned_d;
  logic done_d;
  logic eng_free_d;
  logic last_d;

  always_comb begin
    owned_d    = ping_q | pong_q;
    done_d     = fft_done & owned_d;
    // A handoff already in flight counts as busy even though ping/pong are still low.
    eng_free_d = ~(owned_d | hand_q) | done_d;
`ifdef CORE_FFT_LOAD_DROP_EN
    ready_d  = 1'b1;
    accept_d = din_valid & (state_q == FILL);
    drop_d   = din_valid & (state_q == HOLD);
`else
    ready_d  = (state_q == FILL);
    accept_d = din_valid & ready_d;
    drop_d   = 1'b0;
`endif
    last_d = accept_d & (cnt_q == {LOGPTS{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      fill_bank_q <= 1'b0;
      hand_q      <= 1'b0;
      hand_bank_q <= 1'b0;
      ldata_q     <= '0;
      wa_q        <= '0;
      wen_even_q  <= 1'b0;
      wen_odd_q   <= 1'b0;
      ping_q      <= 1'b0;
      pong_q      <= 1'b0;
      start_q     <= 1'b0;
      ovfl_q      <= 1'b0;
    end else begin
      wen_even_q <= accept_d & ~cnt_q[0];
      wen_odd_q  <= accept_d & cnt_q[0];
      if (accept_d) begin
        ldata_q <= din;
        wa_q    <= cnt_q[LOGPTS-1:1];
        cnt_q   <= cnt_q + LOGPTS'(1);
      end
      if (drop_d) ovfl_q <= 1'b1;

      start_q <= hand_q;
      hand_q  <= 1'b0;
      if (done_d) begin
        ping_q <= 1'b0;
        pong_q <= 1'b0;
      end
      // hand_q is only raised while the engine owns nothing, so it never meets done_d.
      if (hand_q) begin
        ping_q <= ~hand_bank_q;
        pong_q <= hand_bank_q;
      end

      case (state_q)
        FILL: begin
          if (last_d) begin
            if (eng_free_d) begin
              hand_q      <= 1'b1;
              hand_bank_q <= fill_bank_q;
              fill_bank_q <= ~fill_bank_q;
            end else begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hand_q) begin
            state_q <= FILL;
          end else if (done_d) begin
            hand_q      <= 1'b1;
            hand_bank_q <= fill_bank_q;
            fill_bank_q <= ~fill_bank_q;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign din_ready = ready_d;
  assign ldData    = ldata_q;
  assign wA_load   = wa_q;
  assign wEn_even  = wen_even_q;
  assign wEn_odd   = wen_odd_q;
  assign ping      = ping_q;
  assign pong      = pong_q;
  assign fft_start = start_q;
  assign ovfl      = ovfl_q;
  // The final write of a frame lands in the first HOLD cycle, so load stays up for it.
  assign load      = (state_q == FILL) | wen_even_q | wen_odd_q;

endmodule
